switch_allocator: RTL and testbench
===================================

# switch_allocator

Per-router switch allocator that shares the P output ports of the crossbar among the P input queues. Each input queue presents a multi-hot output-port request (multicast). For every output port the allocator independently picks one requesting input by round-robin, gated by a credit counter tracking free slots in the downstream input buffer. Registered grants go back to the input queues, and registered one-hot select and write strobes go to the crossbar.

## Interface
- P, 7, number of router ports (inputs = outputs = P)
- B, 4, downstream buffer address width; downstream depth DEPTH = 2^B flits
- clk  input  1  router clock
- rst_n  input  1  asynchronous, active-low reset
- dest_port_req_all  input  P*P  request from input i at bits [i*P +: P]; bit o set = input i needs output o
- grant_dest_port_all  output  P*P  grant to input i at bits [i*P +: P]; bit o set = output o granted this cycle
- out_sel  output  P*P  crossbar select for output o at bits [o*P +: P]; one-hot on the granted input, zero if idle
- flit_out_wr  output  P  bit o = output o carries a valid flit this cycle
- credit_in  input  P  bit o = downstream buffer on output o released one slot (its flit_rel)
- credit_err  output  1  sticky: credit returned while counter already at DEPTH

## Operation
- One round-robin pointer rr_ptr[o] per output, width clog2(P), pointing to the highest-priority input.
- Eligibility of output o: credit_cnt[o] != 0 (with SA_CREDIT_EN) and at least one input requests o.
- Winner of output o: the first requesting input scanning rr_ptr[o], rr_ptr[o]+1, …, modulo P.
- On a win by input i: grant bit (i,o), out_sel[o] one-hot bit i and flit_out_wr[o] are registered, rr_ptr[o] <= (i+1) mod P, and credit_cnt[o] is decremented.
- Outputs are allocated independently. A multicast input can get any subset of its requested outputs in one cycle; the rest stay requested.
- Requests from an input are not tracked internally. The input queue drops granted bits itself, so the allocator never re-grants a bit it has just granted.
- Credit counters are B+1 bits wide and reset to DEPTH. Each cycle: cnt <= cnt - win[o] + credit_in[o].
- A simultaneous win and credit_in leave cnt unchanged.
- credit_in while cnt == DEPTH with no win: cnt holds at DEPTH (saturates) and credit_err is set until reset.
- A win is never issued at cnt == 0.
- Output ports requested by no input: out_sel = 0, flit_out_wr = 0, and rr_ptr and cnt are unchanged.

## Timing
- Reset values: grant_dest_port_all = 0, out_sel = 0, flit_out_wr = 0, credit_err = 0, all rr_ptr = 0, all credit_cnt = DEPTH.
- All outputs are registered. Requests sampled in cycle t produce grant, out_sel and flit_out_wr in cycle t+1, valid for exactly one cycle.
- There is no combinational path from dest_port_req_all to any output. This is required because the input queue's request depends combinationally on its grant.
- The crossbar muxes flit_to_crossbar using out_sel in the same cycle that grant is high.
- Credit path timing:
  - credit_in in cycle t updates cnt at the end of t.
  - The output is eligible for requests sampled in t+1.
  - The earliest resulting grant is in cycle t+2.
- Throughput: one flit per output per cycle while credits last.
- Reset asserted mid-operation clears all state immediately. Pending requests are re-arbitrated from rr_ptr = 0 after release.

## Configuration
- SA_CREDIT_EN defined: credit counters, credit gating and credit_err behave as described above.
- SA_CREDIT_EN undefined: no counters are built, credit_in is ignored, every requested output is always eligible, and credit_err is tied to 0.

## Test plan
- Reset: hold rst_n low, then release -> all outputs 0, all rr_ptr 0, all credit_cnt 16.
- Single multicast: input 2 requests 7'b0000101 for one cycle -> next cycle:
  - grant bits [14+:7] = 7'b0000101
  - out_sel[0+:7] = out_sel[14+:7] = 7'b0000100
  - flit_out_wr = 7'b0000101
  - rr_ptr[0] = rr_ptr[2] = 3
- Contention: inputs 1, 3 and 5 request output 4, and each drops the request the cycle after its grant -> grants to 1, 3, 5 in three consecutive cycles; final rr_ptr[4] = 6.
- Credit exhaustion (SA_CREDIT_EN):
  - Input 0 requests output 6 continuously -> 16 grants, then none.
  - credit_in[6] pulse in cycle t -> one grant in cycle t+2.
- Simultaneous grant and credit at cnt = 1 -> cnt stays 1 and the grant is issued.
- Overflow: credit_in[3] at cnt = 16 -> cnt stays 16, credit_err = 1 and held until rst_n low.

Source files
------------

// File: rtl/switch_allocator_if.sv
// Allocator bundle: multicast requests and credits in; grants, crossbar selects,
// write strobes and the sticky credit error out.
interface switch_allocator_if #(
  parameter int P = 7
);
  logic [P*P-1:0] dest_port_req_all;
  logic [P*P-1:0] grant_dest_port_all;
  logic [P*P-1:0] out_sel;
  logic [P-1:0]   flit_out_wr;
  logic [P-1:0]   credit_in;
  logic           credit_err;

  // master = input-queue/crossbar side, slave = the allocator
  modport master (
    output dest_port_req_all, credit_in,
    input  grant_dest_port_all, out_sel, flit_out_wr, credit_err
  );

  modport slave (
    input  dest_port_req_all, credit_in,
    output grant_dest_port_all, out_sel, flit_out_wr, credit_err
  );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with fully registered grants/selects.
// Define SA_CREDIT_EN to build downstream credit counters, credit gating and credit_err.
module switch_allocator #(
  parameter int P = 7,
  parameter int B = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  switch_allocator_if.slave sa
);
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int DEPTH = 1 << B;

  logic [P-1:0][P-1:0]  req_by_out;   // [output][input]
  logic [P-1:0][P-1:0]  cand_sel;
  logic [P-1:0][PW-1:0] cand_ptr;
  logic [P-1:0]         credit_ok;
  logic [P-1:0]         win;
  logic [P*P-1:0]       grant_flat;

  logic [P-1:0][P-1:0]  sel_reg;
  logic [P-1:0]         flit_wr_reg;
  logic [P-1:0][PW-1:0] rr_ptr_reg;
  logic [P-1:0][PW-1:0] rr_ptr_next;

  genvar gi, gj;
  generate
    for (gi = 0; gi < P; gi++) begin : g_xpose
      for (gj = 0; gj < P; gj++) begin : g_bit
        assign req_by_out[gj][gi]    = sa.dest_port_req_all[gi*P + gj];
        assign grant_flat[gi*P + gj] = sel_reg[gj][gi];
      end
    end

    for (gi = 0; gi < P; gi++) begin : g_out
      logic [P-1:0]  sel_c;
      logic [PW-1:0] ptr_c;

      // Scan inputs starting at the pointer, wrapping modulo P (P need not be a power of two).
      always_comb begin
        logic [PW:0] idx;
        logic        found;
        sel_c = '0;
        ptr_c = rr_ptr_reg[gi];
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < P; k++) begin
          idx = {1'b0, rr_ptr_reg[gi]} + (PW+1)'(k);
          if (idx >= (PW+1)'(P)) idx = idx - (PW+1)'(P);
          if (!found && req_by_out[gi][idx[PW-1:0]]) begin
            found = 1'b1;
            sel_c[idx[PW-1:0]] = 1'b1;
            ptr_c = (idx == (PW+1)'(P-1)) ? '0 : idx[PW-1:0] + 1'b1;
          end
        end
      end

      assign cand_sel[gi]    = sel_c;
      assign cand_ptr[gi]    = ptr_c;
      assign win[gi]         = (|req_by_out[gi]) && credit_ok[gi];
      assign rr_ptr_next[gi] = win[gi] ? cand_ptr[gi] : rr_ptr_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg     <= '0;
      flit_wr_reg <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      for (int o = 0; o < P; o++) begin
        sel_reg[o] <= win[o] ? cand_sel[o] : '0;
      end
      flit_wr_reg <= win;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

  assign sa.grant_dest_port_all = grant_flat;
  assign sa.out_sel             = sel_reg;
  assign sa.flit_out_wr         = flit_wr_reg;

`ifdef SA_CREDIT_EN
  logic [P-1:0][B:0] credit_cnt_reg;
  logic              credit_err_reg;

  // A win and a returned credit in the same cycle cancel; a credit at full depth saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < P; o++) begin
        credit_cnt_reg[o] <= (B+1)'(DEPTH);
      end
      credit_err_reg <= 1'b0;
    end else begin
      for (int o = 0; o < P; o++) begin
        if (win[o] && !sa.credit_in[o]) begin
          credit_cnt_reg[o] <= credit_cnt_reg[o] - 1'b1;
        end else if (!win[o] && sa.credit_in[o]) begin
          if (credit_cnt_reg[o] == (B+1)'(DEPTH)) begin
            credit_err_reg <= 1'b1;
          end else begin
            credit_cnt_reg[o] <= credit_cnt_reg[o] + 1'b1;
          end
        end
      end
    end
  end

  generate
    for (gi = 0; gi < P; gi++) begin : g_credit
      assign credit_ok[gi] = (credit_cnt_reg[gi] != '0);
    end
  endgenerate

  assign sa.credit_err = credit_err_reg;
`else
  logic unused_credit_in;
  assign unused_credit_in = ^sa.credit_in;
  assign credit_ok        = '1;
  assign sa.credit_err    = 1'b0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed-vector bench for switch_allocator; credit expectations follow SA_CREDIT_EN.
module tb_switch_allocator;
  localparam int P = 7;
  localparam int B = 4;
`ifdef SA_CREDIT_EN
  localparam bit CR = 1'b1;
`else
  localparam bit CR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_grants;

  switch_allocator_if #(.P(P)) sa_bus ();

  switch_allocator #(.P(P), .B(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sa    (sa_bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] gbit(input int i, input int o);
    logic [63:0] v;
    v = '0;
    v[i*P + o] = 1'b1;
    return v;
  endfunction

  initial begin
    sa_bus.dest_port_req_all = '0;
    sa_bus.credit_in         = '0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_grant", 64'(sa_bus.grant_dest_port_all), 64'h0);
    check_eq("rst_out_sel", 64'(sa_bus.out_sel), 64'h0);
    check_eq("rst_flit_wr", 64'(sa_bus.flit_out_wr), 64'h0);
    check_eq("rst_credit_err", 64'(sa_bus.credit_err), 64'h0);
    rst_n = 1'b1;
    tick;
    check_eq("rst_rr_ptr", 64'(dut.rr_ptr_reg), 64'h0);
`ifdef SA_CREDIT_EN
    check_eq("rst_credit_cnt", 64'(dut.credit_cnt_reg), {29'h0, {7{5'd16}}});
`endif

    // Single multicast: input 2 -> outputs 0 and 2
    sa_bus.dest_port_req_all[2*P +: P] = 7'b0000101;
    tick;
    sa_bus.dest_port_req_all = '0;
    check_eq("mc_grant", 64'(sa_bus.grant_dest_port_all), 64'h5 << 14);
    check_eq("mc_out_sel", 64'(sa_bus.out_sel), 64'h4 | (64'h4 << 14));
    check_eq("mc_flit_wr", 64'(sa_bus.flit_out_wr), 64'h5);
    check_eq("mc_rr_ptr0", 64'(dut.rr_ptr_reg[0]), 64'd3);
    check_eq("mc_rr_ptr2", 64'(dut.rr_ptr_reg[2]), 64'd3);
    check_eq("mc_rr_ptr1", 64'(dut.rr_ptr_reg[1]), 64'd0);
    tick;
    check_eq("mc_grant_oneshot", 64'(sa_bus.grant_dest_port_all), 64'h0);
    check_eq("mc_flit_oneshot", 64'(sa_bus.flit_out_wr), 64'h0);

    // Contention on output 4 from inputs 1, 3, 5
    sa_bus.dest_port_req_all[1*P + 4] = 1'b1;
    sa_bus.dest_port_req_all[3*P + 4] = 1'b1;
    sa_bus.dest_port_req_all[5*P + 4] = 1'b1;
    tick;
    check_eq("ct_grant_in1", 64'(sa_bus.grant_dest_port_all), gbit(1, 4));
    check_eq("ct_out_sel_in1", 64'(sa_bus.out_sel), 64'h2 << 28);
    check_eq("ct_flit_in1", 64'(sa_bus.flit_out_wr), 64'h10);
    sa_bus.dest_port_req_all[1*P + 4] = 1'b0;
    tick;
    check_eq("ct_grant_in3", 64'(sa_bus.grant_dest_port_all), gbit(3, 4));
    sa_bus.dest_port_req_all[3*P + 4] = 1'b0;
    tick;
    check_eq("ct_grant_in5", 64'(sa_bus.grant_dest_port_all), gbit(5, 4));
    check_eq("ct_out_sel_in5", 64'(sa_bus.out_sel), 64'h20 << 28);
    sa_bus.dest_port_req_all[5*P + 4] = 1'b0;
    check_eq("ct_rr_ptr4", 64'(dut.rr_ptr_reg[4]), 64'd6);
    tick;
    check_eq("ct_idle", 64'(sa_bus.grant_dest_port_all), 64'h0);

    // Pointer wrap: rr_ptr[4] = 6, inputs 0 and 6 request
    sa_bus.dest_port_req_all[0*P + 4] = 1'b1;
    sa_bus.dest_port_req_all[6*P + 4] = 1'b1;
    tick;
    check_eq("wr_grant_in6", 64'(sa_bus.grant_dest_port_all), gbit(6, 4));
    check_eq("wr_rr_ptr4_wrap", 64'(dut.rr_ptr_reg[4]), 64'd0);
    sa_bus.dest_port_req_all[6*P + 4] = 1'b0;
    tick;
    check_eq("wr_grant_in0", 64'(sa_bus.grant_dest_port_all), gbit(0, 4));
    check_eq("wr_rr_ptr4", 64'(dut.rr_ptr_reg[4]), 64'd1);
    sa_bus.dest_port_req_all[0*P + 4] = 1'b0;
`ifdef SA_CREDIT_EN
    check_eq("wr_credit_cnt4", 64'(dut.credit_cnt_reg[4]), 64'd11);
`endif
    tick;

    // Credit exhaustion on output 6 from input 0
    sa_bus.dest_port_req_all[0*P + 6] = 1'b1;
    n_grants = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (sa_bus.flit_out_wr[6]) n_grants++;
    end
    check_eq("ex_grant_count", 64'(n_grants), CR ? 64'd16 : 64'd20);
    check_eq("ex_last_flit", 64'(sa_bus.flit_out_wr[6]), CR ? 64'd0 : 64'd1);

    // Credit pulse in cycle t -> one grant in t+2
    sa_bus.credit_in[6] = 1'b1;
    tick;
    sa_bus.credit_in[6] = 1'b0;
    check_eq("cp_flit_t1", 64'(sa_bus.flit_out_wr[6]), CR ? 64'd0 : 64'd1);
    tick;
    check_eq("cp_flit_t2", 64'(sa_bus.flit_out_wr[6]), 64'd1);
    tick;
    check_eq("cp_flit_t3", 64'(sa_bus.flit_out_wr[6]), CR ? 64'd0 : 64'd1);

    // Simultaneous win and credit at cnt = 1
    sa_bus.credit_in[6] = 1'b1;
    tick;
    check_eq("sw_flit_pre", 64'(sa_bus.flit_out_wr[6]), CR ? 64'd0 : 64'd1);
    tick;
    sa_bus.credit_in[6] = 1'b0;
    sa_bus.dest_port_req_all = '0;
    check_eq("sw_flit", 64'(sa_bus.flit_out_wr[6]), 64'd1);
`ifdef SA_CREDIT_EN
    check_eq("sw_credit_cnt6", 64'(dut.credit_cnt_reg[6]), 64'd1);
`endif
    tick;
    check_eq("sw_flit_idle", 64'(sa_bus.flit_out_wr[6]), 64'd0);
`ifdef SA_CREDIT_EN
    check_eq("sw_credit_cnt6_hold", 64'(dut.credit_cnt_reg[6]), 64'd1);
`endif
    check_eq("sw_no_err", 64'(sa_bus.credit_err), 64'd0);

    // Overflow: credit on output 3 at full depth
    sa_bus.credit_in[3] = 1'b1;
    tick;
    sa_bus.credit_in[3] = 1'b0;
    check_eq("ov_credit_err", 64'(sa_bus.credit_err), 64'(CR));
`ifdef SA_CREDIT_EN
    check_eq("ov_credit_cnt3", 64'(dut.credit_cnt_reg[3]), 64'd16);
`endif
    repeat (3) tick;
    check_eq("ov_credit_err_sticky", 64'(sa_bus.credit_err), 64'(CR));

    // Asynchronous reset mid-operation, then re-arbitration from rr_ptr = 0
    sa_bus.dest_port_req_all[2*P + 0] = 1'b1;
    sa_bus.dest_port_req_all[5*P + 0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_credit_err", 64'(sa_bus.credit_err), 64'd0);
    check_eq("ar_rr_ptr", 64'(dut.rr_ptr_reg), 64'h0);
    check_eq("ar_grant", 64'(sa_bus.grant_dest_port_all), 64'h0);
    tick;
    rst_n = 1'b1;
    tick;
    check_eq("ar_regrant_in2", 64'(sa_bus.grant_dest_port_all), gbit(2, 0));
    check_eq("ar_out_sel0", 64'(sa_bus.out_sel), 64'h4);
    sa_bus.dest_port_req_all = '0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
